bus_split_arbiter: RTL
======================

Name: bus_split_arbiter

Overview:
- Central arbiter for the serial system bus, shared by 2 masters and NUM_SLAVES slave ports.
- Grants bus ownership and drives the master-select and slave-select controls for the address/data/burst muxes.
- Handles split transactions: when a slave raises split_en, the bus is released to the other master. The split master is resumed once that slave drops split_en.

Parameters:
- NUM_SLAVES, 3, number of slave ports on the bus
- SLAVE_ID_W, 2, width of slave index, must satisfy 2**SLAVE_ID_W >= NUM_SLAVES

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- m_req  in  2  per-master bus request, level, held until m_done
- m_done  in  2  per-master one-cycle pulse, transaction complete
- m_slave_id  in  2*SLAVE_ID_W  target slave per master; master i occupies bits [i*SLAVE_ID_W +: SLAVE_ID_W]; sampled at grant
- split_en  in  NUM_SLAVES  per-slave split indication from slave ports
- m_grant  out  2  one-hot or zero, bus granted to master
- m_split_wait  out  2  master's transaction suspended by split; master holds its state
- bus_owner  out  1  master mux select, index of current or last owner
- slave_sel  out  SLAVE_ID_W  slave demux select
- slave_sel_valid  out  1  slave_sel is meaningful this cycle
- bus_busy  out  1  any grant active

Behaviour:
- Reset values: m_grant=0, m_split_wait=0, bus_owner=0, slave_sel=0, slave_sel_valid=0, bus_busy=0, state=IDLE, no split recorded.
- States: IDLE, GRANT, SPLIT_OTHER, RESUME.
- Arbitration decision is made in IDLE only. Grant is asserted the cycle after m_req is seen in IDLE (1-cycle latency).
- Default priority is fixed: master 0 wins over master 1.
- On grant, latch the owner's m_slave_id into slave_sel, assert slave_sel_valid, and set bus_owner.
- IDLE -> GRANT: at least one m_req is eligible. A master is ineligible while it is in split wait.
- GRANT -> IDLE: owner's m_done pulses. m_grant is cleared the next cycle, giving a minimum 1-cycle turnaround; no back-to-back grant.
- GRANT -> SPLIT_OTHER: split_en[slave_sel]=1 while the owner is in GRANT.
  - Record split_master=owner and split_slave=slave_sel.
  - Clear the owner's grant and set m_split_wait[owner].
- SPLIT_OTHER, other master requesting a slave other than split_slave: grant it with the normal GRANT bookkeeping. Stay in the split context; the split record is retained.
- SPLIT_OTHER, other master requesting split_slave: it is ineligible and stays ungranted.
- Split release: split_en[split_slave]=0.
  - If no other transaction is active, go to RESUME.
  - Else wait for the other master's m_done, then go to RESUME. The other master is not preempted.
- RESUME: regrant split_master with slave_sel=split_slave, clear m_split_wait, go to GRANT.
  - Resume wins over any new request, including master 0.
- A nested split (other master split while a split is recorded) is not supported. Its split_en is ignored until the first split resolves; this is a documented limitation.
- Simultaneous m_done and split_en on the owner's slave: m_done wins, go to IDLE.
- m_done from a non-owner is ignored.
- m_req dropping without m_done while granted: the grant is held. The bus error is flagged only in simulation.
- slave_sel index >= NUM_SLAVES: treat split_en as 0. No assertion is required in RTL.
- Reset asserted mid-transaction or mid-split: all outputs and records return to reset values immediately (async).

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: a last_grant register toggles priority, so the master not granted last wins a tie in IDLE. Split resume still has absolute priority.
- Undefined: fixed priority, master 0 first, and last_grant logic is absent.

Decomposition:
- Shared package bus_pkg:
  - state encoding constants IDLE/GRANT/SPLIT_OTHER/RESUME
  - master index constants M0/M1
  - SLAVE_ID_W default
- One natural sub-module: arb_priority_pick.
  - Combinational 2-way pick from eligible requests plus last_grant.
  - Reused by the round-robin and fixed modes.

Test Plan:
- m_req=2'b11 in IDLE -> next cycle m_grant=2'b01, bus_owner=0. m_done[0] pulse -> m_grant=0 for 1 cycle, then m_grant=2'b10.
- M0 granted to slave 2; split_en[2]=1 -> m_grant=0, m_split_wait=2'b01. M1 req to slave 1 -> m_grant=2'b10, slave_sel=1.
- Continue: split_en[2] drops while M1 busy -> M0 not granted until m_done[1]. Then m_grant=2'b01, slave_sel=2, m_split_wait=0.
- M0 split on slave 1, M1 requests slave 1 -> M1 never granted until the split resolves and M0 completes.
- ARB_ROUND_ROBIN_EN defined, m_req held 2'b11 -> grants alternate 01,10,01. Undefined -> always 01 first.
- Assert reset in SPLIT_OTHER with m_grant=2'b10 -> all outputs 0 asynchronously. After release, m_req=2'b01 -> grant 01 next cycle.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared arbiter state encoding, master indices and default widths
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GRANT       = 2'd1,
        SPLIT_OTHER = 2'd2,
        RESUME      = 2'd3
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int SLAVE_ID_W_DEF = 2;

endpackage

// File: rtl/arb_priority_pick.sv
// rtl/arb_priority_pick.sv - two-way request pick, tie broken against the last granted master
module arb_priority_pick
    import bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       pick_valid,
    output logic       pick_idx
);

    // On a tie the master that did not win last time gets the bus; a lone request always wins
    always_comb begin
        pick_valid = |req;
        pick_idx   = M0;
        if (req == 2'b11) begin
            pick_idx = ~last_grant;
        end else if (req[1]) begin
            pick_idx = M1;
        end
    end

endmodule

// File: rtl/bus_split_arbiter.sv
// rtl/bus_split_arbiter.sv - split-capable bus arbiter for 2 masters; ARB_ROUND_ROBIN_EN selects round-robin tie-break
module bus_split_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_SLAVES = 3,
    parameter int SLAVE_ID_W = SLAVE_ID_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              m_req,
    input  logic [1:0]              m_done,
    input  logic [2*SLAVE_ID_W-1:0] m_slave_id,
    input  logic [NUM_SLAVES-1:0]   split_en,
    output logic [1:0]              m_grant,
    output logic [1:0]              m_split_wait,
    output logic                    bus_owner,
    output logic [SLAVE_ID_W-1:0]   slave_sel,
    output logic                    slave_sel_valid,
    output logic                    bus_busy
);

    arb_state_t            state;
    logic                  split_master;
    logic [SLAVE_ID_W-1:0] split_slave;
    logic                  split_released;
    logic                  last_grant;

    logic [SLAVE_ID_W-1:0] m0_id;
    logic [SLAVE_ID_W-1:0] m1_id;
    logic                  other;
    logic                  split_cur;
    logic                  split_rec;
    logic                  release_now;
    logic [1:0]            eligible;
    logic                  pick_valid;
    logic                  pick_idx;

    logic                  issue;
    logic                  g_idx;
    logic [SLAVE_ID_W-1:0] g_sel;

    assign m0_id       = m_slave_id[SLAVE_ID_W-1:0];
    assign m1_id       = m_slave_id[2*SLAVE_ID_W-1:SLAVE_ID_W];
    assign other       = ~split_master;
    assign eligible    = m_req & ~m_split_wait;
    assign release_now = split_released | ~split_rec;

    // Look up split_en for the active slave and for the recorded split slave; indices past the last port read as 0
    always_comb begin
        split_cur = 1'b0;
        split_rec = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (int'(slave_sel) == i) split_cur = split_en[i];
            if (int'(split_slave) == i) split_rec = split_en[i];
        end
    end

    arb_priority_pick u_pick (
        .req        (eligible),
        .last_grant (last_grant),
        .pick_valid (pick_valid),
        .pick_idx   (pick_idx)
    );

    // Decide whether a new grant is issued this cycle, to whom, and for which slave
    always_comb begin
        issue = 1'b0;
        g_idx = M0;
        g_sel = '0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    issue = 1'b1;
                    g_idx = pick_idx;
                    g_sel = pick_idx ? m1_id : m0_id;
                end
            end
            SPLIT_OTHER: begin
                // The other master may use the bus, but never the slave that is holding the split
                if (!m_grant[other] && !release_now && m_req[other] &&
                    ((other ? m1_id : m0_id) != split_slave)) begin
                    issue = 1'b1;
                    g_idx = other;
                    g_sel = other ? m1_id : m0_id;
                end
            end
            RESUME: begin
                issue = 1'b1;
                g_idx = split_master;
                g_sel = split_slave;
            end
            default: ;
        endcase
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember who was granted last so the other master wins the next tie; starts favouring M0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= M1;
        end else if (issue) begin
            last_grant <= g_idx;
        end
    end
`else
    assign last_grant = M1;
`endif

    // Arbitration FSM with registered grant, split bookkeeping and mux controls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            m_grant         <= 2'b00;
            m_split_wait    <= 2'b00;
            bus_owner       <= M0;
            slave_sel       <= '0;
            slave_sel_valid <= 1'b0;
            bus_busy        <= 1'b0;
            split_master    <= M0;
            split_slave     <= '0;
            split_released  <= 1'b0;
        end else begin
            if (issue) begin
                m_grant         <= g_idx ? 2'b10 : 2'b01;
                bus_owner       <= g_idx;
                slave_sel       <= g_sel;
                slave_sel_valid <= 1'b1;
                bus_busy        <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (issue) state <= GRANT;
                end
                GRANT: begin
                    // Completion beats a split raised in the same cycle
                    if (m_done[bus_owner]) begin
                        m_grant         <= 2'b00;
                        slave_sel_valid <= 1'b0;
                        bus_busy        <= 1'b0;
                        state           <= IDLE;
                    end else if (split_cur) begin
                        split_master    <= bus_owner;
                        split_slave     <= slave_sel;
                        split_released  <= 1'b0;
                        m_split_wait    <= bus_owner ? 2'b10 : 2'b01;
                        m_grant         <= 2'b00;
                        slave_sel_valid <= 1'b0;
                        bus_busy        <= 1'b0;
                        state           <= SPLIT_OTHER;
                    end
                end
                SPLIT_OTHER: begin
                    if (m_grant[other]) begin
                        // Release seen while the other master owns the bus is held until it finishes
                        if (!split_rec) split_released <= 1'b1;
                        if (m_done[other]) begin
                            m_grant         <= 2'b00;
                            slave_sel_valid <= 1'b0;
                            bus_busy        <= 1'b0;
                            if (release_now) state <= RESUME;
                        end
                    end else if (release_now) begin
                        state <= RESUME;
                    end
                end
                RESUME: begin
                    m_split_wait   <= 2'b00;
                    split_released <= 1'b0;
                    state          <= GRANT;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
